cntr_bs_dp_param: RTL and testbench

CNTR_BS_DP_PARAM -- requirements
Module: cntr_bs_dp_param

---
 rtl/cntr_bs_dp_param_if.sv | 53 +++++
 rtl/cntr_bs_dp_param.sv | 176 +++++++++++++++++
 tb/tb_cntr_bs_dp_param.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cntr_bs_dp_param_if.sv
// Bundle of request, status and output signals for the cntr_bs_dp_param FIFO bank.
// Ports: push/pop selects and request fields in; grant, full/mid/empty, last_ra,
//        first_burst, occ, registered output record and err_o out.
interface cntr_bs_dp_param_if #(
  parameter int RD_FIFO_NUM  = 4,
  parameter int WR_FIFO_NUM  = 3,
  parameter int RD_FIFO_SIZE = 4,
  parameter int WR_FIFO_SIZE = 3,
  parameter int DQ           = 16,
  parameter int IDX          = 6,
  parameter int RA           = 16,
  parameter int CA           = 10
) ();
  localparam int N     = RD_FIFO_NUM + WR_FIFO_NUM;
  localparam int SB    = (N > 1) ? $clog2(N) : 1;
  localparam int MAXD  = (RD_FIFO_SIZE > WR_FIFO_SIZE) ? RD_FIFO_SIZE : WR_FIFO_SIZE;
  localparam int CW    = $clog2(MAXD + 1);
  localparam int BURST = RA + CA - 4;

  logic [N-1:0]       push;
  logic [N-1:0]       pop;
  logic [DQ-1:0]      dq_i;
  logic [IDX-1:0]     idx_i;
  logic [RA-1:0]      ra_i;
  logic [CA-1:0]      ca_i;
  logic               grant;
  logic [N-1:0]       full;
  logic [N-1:0]       mid;
  logic [N-1:0]       empty;
  logic [N*RA-1:0]    last_ra;
  logic [N*BURST-1:0] first_burst;
  logic [N*CW-1:0]    occ;
  logic               out_valid;
  logic [DQ-1:0]      dq_o;
  logic [IDX-1:0]     idx_o;
  logic [RA-1:0]      ra_o;
  logic [CA-1:0]      ca_o;
  logic               type_o;
  logic [SB-1:0]      src_o;
  logic [2:0]         err_o;

  modport master (
    output push, pop, dq_i, idx_i, ra_i, ca_i,
    input  grant, full, mid, empty, last_ra, first_burst, occ,
    input  out_valid, dq_o, idx_o, ra_o, ca_o, type_o, src_o, err_o
  );

  modport slave (
    input  push, pop, dq_i, idx_i, ra_i, ca_i,
    output grant, full, mid, empty, last_ra, first_burst, occ,
    output out_valid, dq_o, idx_o, ra_o, ca_o, type_o, src_o, err_o
  );
endinterface

// File: rtl/cntr_bs_dp_param.sv
// Bank of read FIFOs {idx,ra,ca} and write FIFOs {dq,idx,ra,ca} with a registered exit mux.
// Latency: accepted one-hot pop -> out_valid 1 clock later; status flags are combinational from occ.
// Backpressure: push to a full FIFO is dropped, pop of an empty FIFO or a multi-hot pop is ignored.
// Ports: clk, rst (async active-high), bus (cntr_bs_dp_param_if.slave).
// Optional macro CNTR_BS_DP_PARAM_ERR_EN enables sticky err_o {multi_hot, underflow, overflow};
// without it err_o is tied to 0.
module cntr_bs_dp_param #(
  parameter int RD_FIFO_NUM  = 4,
  parameter int WR_FIFO_NUM  = 3,
  parameter int RD_FIFO_SIZE = 4,
  parameter int WR_FIFO_SIZE = 3,
  parameter int DQ           = 16,
  parameter int IDX          = 6,
  parameter int RA           = 16,
  parameter int CA           = 10
) (
  input logic              clk,
  input logic              rst,
  cntr_bs_dp_param_if.slave bus
);
  localparam int N     = RD_FIFO_NUM + WR_FIFO_NUM;
  localparam int SB    = (N > 1) ? $clog2(N) : 1;
  localparam int MAXD  = (RD_FIFO_SIZE > WR_FIFO_SIZE) ? RD_FIFO_SIZE : WR_FIFO_SIZE;
  localparam int CW    = $clog2(MAXD + 1);
  localparam int BURST = RA + CA - 4;
  localparam int PW    = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int RW    = IDX + RA + CA;
  localparam int WW    = DQ + RW;
  localparam logic [N-1:0] ONE_N = N'(1);

  logic [N-1:0]    full_c, empty_c, mid_c, push_acc, pop_acc;
  logic [N*DQ-1:0]  head_dq_f;
  logic [N*IDX-1:0] head_idx_f;
  logic [N*RA-1:0]  head_ra_f;
  logic [N*CA-1:0]  head_ca_f;
  logic            multi_hot;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hot = (bus.pop & (bus.pop - ONE_N)) != '0;
  assign bus.grant = |bus.push;

  for (genvar k = 0; k < N; k++) begin : g_fifo
    localparam bit  IS_RD = (k < RD_FIFO_NUM);
    localparam int  D     = IS_RD ? RD_FIFO_SIZE : WR_FIFO_SIZE;
    localparam int  EW    = IS_RD ? RW : WW;
    localparam logic [CW-1:0] D_C    = CW'(D);
    localparam logic [CW-1:0] HALF_C = CW'((D + 1) / 2);
    localparam logic [PW-1:0] LAST_P = PW'(D - 1);

    logic [EW-1:0] mem [D];
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] occ_q;
    logic [RA-1:0] last_ra_q;

    assign full_c[k]  = (occ_q == D_C);
    assign empty_c[k] = (occ_q == '0);
    assign mid_c[k]   = (occ_q >= HALF_C);

    // A full FIFO still accepts a push when the same cycle pops it; an empty one never
    // pops, so push+pop on empty is a plain push.
    assign pop_acc[k]  = bus.pop[k] && !multi_hot && !empty_c[k];
    assign push_acc[k] = bus.push[k] && (!full_c[k] || pop_acc[k]);

    assign head = mem[rd_ptr];

    if (IS_RD) begin : g_rd
      assign entry = {bus.idx_i, bus.ra_i, bus.ca_i};
      assign head_dq_f[k*DQ +: DQ] = '0;
    end else begin : g_wr
      assign entry = {bus.dq_i, bus.idx_i, bus.ra_i, bus.ca_i};
      assign head_dq_f[k*DQ +: DQ] = head[RW +: DQ];
    end

    assign head_idx_f[k*IDX +: IDX] = head[CA+RA +: IDX];
    assign head_ra_f[k*RA +: RA]    = head[CA +: RA];
    assign head_ca_f[k*CA +: CA]    = head[CA-1:0];

    assign bus.occ[k*CW +: CW]   = occ_q;
    assign bus.last_ra[k*RA +: RA] = last_ra_q;
    assign bus.first_burst[k*BURST +: BURST] =
      empty_c[k] ? '0 : {head[CA +: RA], head[CA-1:4]};

    always_ff @(posedge clk) begin
      if (push_acc[k]) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        occ_q     <= '0;
        last_ra_q <= '0;
      end else begin
        if (push_acc[k]) begin
          wr_ptr    <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
          last_ra_q <= bus.ra_i;
        end
        if (pop_acc[k]) rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
        if (push_acc[k] && !pop_acc[k])      occ_q <= occ_q + 1'b1;
        else if (pop_acc[k] && !push_acc[k]) occ_q <= occ_q - 1'b1;
      end
    end
  end

  assign bus.full  = full_c;
  assign bus.empty = empty_c;
  assign bus.mid   = mid_c;

  // Exit mux: pop_acc is at most one-hot, so OR-ing the masked heads selects the winner.
  logic [DQ-1:0]  sel_dq;
  logic [IDX-1:0] sel_idx;
  logic [RA-1:0]  sel_ra;
  logic [CA-1:0]  sel_ca;
  logic [SB-1:0]  sel_src;
  logic           sel_type;

  always_comb begin
    sel_dq   = '0;
    sel_idx  = '0;
    sel_ra   = '0;
    sel_ca   = '0;
    sel_src  = '0;
    sel_type = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (pop_acc[k]) begin
        sel_dq  = sel_dq  | head_dq_f[k*DQ +: DQ];
        sel_idx = sel_idx | head_idx_f[k*IDX +: IDX];
        sel_ra  = sel_ra  | head_ra_f[k*RA +: RA];
        sel_ca  = sel_ca  | head_ca_f[k*CA +: CA];
        sel_src = sel_src | SB'(k);
        if (k < RD_FIFO_NUM) sel_type = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.dq_o      <= '0;
      bus.idx_o     <= '0;
      bus.ra_o      <= '0;
      bus.ca_o      <= '0;
      bus.type_o    <= 1'b0;
      bus.src_o     <= '0;
    end else begin
      bus.out_valid <= |pop_acc;
      // Output record holds its last value when nothing is popped.
      if (|pop_acc) begin
        bus.dq_o   <= sel_dq;
        bus.idx_o  <= sel_idx;
        bus.ra_o   <= sel_ra;
        bus.ca_o   <= sel_ca;
        bus.type_o <= sel_type;
        bus.src_o  <= sel_src;
      end
    end
  end

`ifdef CNTR_BS_DP_PARAM_ERR_EN
  logic [2:0] err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (|(bus.push & full_c & ~pop_acc))        err_q[0] <= 1'b1;
      if (!multi_hot && |(bus.pop & empty_c))     err_q[1] <= 1'b1;
      if (multi_hot)                              err_q[2] <= 1'b1;
    end
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 3'b000;
`endif
endmodule

// File: tb/tb_cntr_bs_dp_param.sv
module tb_cntr_bs_dp_param;
  localparam int N = 7, RDN = 4, CW = 3, BURST = 22;

  typedef struct {
    logic [15:0] dq;
    logic [5:0]  idx;
    logic [15:0] ra;
    logic [9:0]  ca;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cntr_bs_dp_param_if bus ();
  cntr_bs_dp_param dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per FIFO plus the expected output record.
  ent_t        mq [N][$];
  int          depth [N] = '{4, 4, 4, 4, 3, 3, 3};
  logic [15:0] m_last_ra [N];
  logic [2:0]  m_err;
  logic        m_ov, m_type;
  logic [15:0] m_dq, m_ra;
  logic [5:0]  m_idx;
  logic [9:0]  m_ca;
  logic [2:0]  m_src;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      m_last_ra[k] = '0;
    end
    m_err = '0; m_ov = 0; m_type = 0; m_dq = '0; m_ra = '0; m_idx = '0; m_ca = '0; m_src = '0;
  endtask

  task automatic model_update(input logic [6:0] pu, input logic [6:0] po, input ent_t e);
    int nset;
    logic multi, pa, acc;
    ent_t h, ne;
    nset = $countones(po);
    multi = (nset > 1);
    m_ov = 0;
    for (int k = 0; k < N; k++) begin
      pa  = po[k] && !multi && (mq[k].size() > 0);
      acc = pu[k] && ((mq[k].size() < depth[k]) || pa);
`ifdef CNTR_BS_DP_PARAM_ERR_EN
      if (pu[k] && !acc) m_err[0] = 1;
      if (po[k] && !multi && mq[k].size() == 0) m_err[1] = 1;
`endif
      if (pa) begin
        h = mq[k].pop_front();
        m_ov = 1; m_src = 3'(k); m_type = (k < RDN);
        m_dq = (k < RDN) ? 16'h0 : h.dq;
        m_idx = h.idx; m_ra = h.ra; m_ca = h.ca;
      end
      if (acc) begin
        ne = e;
        if (k < RDN) ne.dq = '0;
        mq[k].push_back(ne);
        m_last_ra[k] = e.ra;
      end
    end
`ifdef CNTR_BS_DP_PARAM_ERR_EN
    if (multi) m_err[2] = 1;
`endif
  endtask

  task automatic check_all();
    int sz;
    logic [21:0] fb;
    for (int k = 0; k < N; k++) begin
      sz = mq[k].size();
      fb = (sz > 0) ? {mq[k][0].ra, mq[k][0].ca[9:4]} : 22'h0;
      chk("occ", k, bus.occ[k*CW +: CW], sz);
      chk("full", k, bus.full[k], sz == depth[k]);
      chk("empty", k, bus.empty[k], sz == 0);
      chk("mid", k, bus.mid[k], sz >= (depth[k] + 1) / 2);
      chk("last_ra", k, bus.last_ra[k*16 +: 16], m_last_ra[k]);
      chk("first_burst", k, bus.first_burst[k*BURST +: BURST], fb);
    end
    chk("out_valid", 0, bus.out_valid, m_ov);
    chk("dq_o", 0, bus.dq_o, m_dq);
    chk("idx_o", 0, bus.idx_o, m_idx);
    chk("ra_o", 0, bus.ra_o, m_ra);
    chk("ca_o", 0, bus.ca_o, m_ca);
    chk("type_o", 0, bus.type_o, m_type);
    chk("src_o", 0, bus.src_o, m_src);
    chk("err_o", 0, bus.err_o, m_err);
  endtask

  // One clock: apply inputs, check grant, clock, advance the model, compare everything.
  task automatic step(input logic [6:0] pu, input logic [6:0] po, input ent_t e);
    bus.push = pu; bus.pop = po;
    bus.dq_i = e.dq; bus.idx_i = e.idx; bus.ra_i = e.ra; bus.ca_i = e.ca;
    #1;
    chk("grant", 0, bus.grant, |pu);
    @(posedge clk); #1;
    model_update(pu, po, e);
    bus.push = '0; bus.pop = '0;
    check_all();
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.dq = 16'($urandom); e.idx = 6'($urandom); e.ra = 16'($urandom); e.ca = 10'($urandom);
    return e;
  endfunction

  initial begin
    ent_t e;
    logic [2:0] exp_err;
    int r;
    logic [6:0] pu, po;

    bus.push = '0; bus.pop = '0; bus.dq_i = '0; bus.idx_i = '0; bus.ra_i = '0; bus.ca_i = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Fill read FIFO 0 with ra=1..4, then a fifth push is dropped.
    for (int i = 1; i <= 5; i++) begin
      e = rnd_ent(); e.ra = 16'(i);
      step(7'b0000001, 7'b0, e);
    end
    chk("s1_full0", 0, bus.full[0], 1'b1);
    chk("s1_last_ra0", 0, bus.last_ra[15:0], 16'd4);
`ifdef CNTR_BS_DP_PARAM_ERR_EN
    exp_err = 3'b001;
`else
    exp_err = 3'b000;
`endif
    chk("s1_err", 0, bus.err_o, exp_err);

    // Single write entry through FIFO 5.
    e.dq = 16'hBEEF; e.idx = 6'd3; e.ra = 16'd7; e.ca = 10'h3F0;
    step(7'b0100000, 7'b0, e);
    step(7'b0, 7'b0100000, rnd_ent());
    chk("s2_valid", 5, bus.out_valid, 1'b1);
    chk("s2_dq", 5, bus.dq_o, 16'hBEEF);
    chk("s2_src", 5, bus.src_o, 3'd5);
    chk("s2_type", 5, bus.type_o, 1'b0);
    chk("s2_idx", 5, bus.idx_o, 6'd3);
    chk("s2_fb", 5, bus.first_burst[5*BURST +: BURST], 22'h0);
    step(7'b0, 7'b0, rnd_ent());

    // Fill FIFO 2, then six simultaneous push+pop across the pointer wrap.
    for (int i = 0; i < 4; i++) step(7'b0000100, 7'b0, rnd_ent());
    for (int i = 0; i < 6; i++) step(7'b0000100, 7'b0000100, rnd_ent());
    chk("s3_occ2", 2, bus.occ[2*CW +: CW], 3'd4);

    // Multi-hot pop with FIFOs 0 and 1 both holding data.
    step(7'b0000010, 7'b0, rnd_ent());
    step(7'b0, 7'b0000011, rnd_ent());
    chk("s4_valid", 0, bus.out_valid, 1'b0);
    chk("s4_occ0", 0, bus.occ[0 +: CW], 3'd4);

    // Reset during an out_valid cycle.
    step(7'b0, 7'b0000001, rnd_ent());
    chk("s5_pre_valid", 0, bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("s5_empty", 0, bus.empty, 7'h7F);
    chk("s5_valid", 0, bus.out_valid, 1'b0);
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    step(7'b0, 7'b0, rnd_ent());

    // Random one-hot traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 8);
      pu = (r < N) ? (7'b1 << r) : 7'b0;
      r = $urandom_range(0, 9);
      po = (r < N) ? (7'b1 << r) : 7'b0;
      step(pu, po, rnd_ent());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
